seq_div_unit: RTL and testbench

Iterative signed 32-bit divider executing the MIPS `div` instruction for the multicycle core. It takes operands from the A/B registers on a one-cycle `start` pulse from the control unit. It produces the quotient (to LO) and remainder (to HI) after a fixed number of cycles, then raises a one-cycle `ready` and a divide-by-zero flag for the exception path. The block sits directly downstream of the A/B operand registers and upstream of the HI/LO registers.

---
 rtl/seq_div_unit_pkg.sv | 14 +
 rtl/seq_div_unit_if.sv | 16 +
 rtl/seq_div_unit_step.sv | 23 ++
 rtl/seq_div_unit.sv | 113 +++++++++++
 tb/tb_seq_div_unit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seq_div_unit_pkg.sv
// Shared CPU definitions used by the iterative divider.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/seq_div_unit_if.sv
// Control-unit <-> divider bundle: operands and start in, results and status out.
interface seq_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ready;
  logic             div_zero;
  logic             busy;

  modport master (output start, a, b, input hi, lo, ready, div_zero, busy);
  modport slave  (input start, a, b, output hi, lo, ready, div_zero, busy);
endinterface

// File: rtl/seq_div_unit_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Shift {rem, quo} left, trial-subtract, keep the difference only if non-negative.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor};
    rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/seq_div_unit.sv
// Iterative signed divider for MIPS div: quotient to lo, remainder to hi.
// Magnitudes are divided unsigned, signs are restored in the FIX state.
module seq_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  seq_div_unit_if.slave  dif
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_a_q, sign_q_q, dz_q;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_neg  = dif.a[WIDTH-1];
    b_neg  = dif.b[WIDTH-1];
    b_zero = (dif.b == '0);
    a_abs  = a_neg ? (~dif.a + 1'b1) : dif.a;
    b_abs  = b_neg ? (~dif.b + 1'b1) : dif.b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (dif.start) state_nxt = b_zero ? DONE : ITER;
      ITER: if (cnt_q == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    dif.ready    = (state == DONE);
    dif.div_zero = (state == DONE) && dz_q;
    dif.busy     = (state != IDLE);
  end

  // Datapath: operand capture, iteration, sign fix of the results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.start) begin
            if (b_zero) begin
              dz_q <= 1'b1;
            end else begin
              rem_q    <= '0;
              quo_q    <= a_abs;
              dvs_q    <= b_abs;
              sign_a_q <= a_neg;
              sign_q_q <= a_neg ^ b_neg;
              cnt_q    <= CW'(WIDTH - 1);
            end
          end
        end
        ITER: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          lo_q <= sign_q_q ? (~quo_q + 1'b1) : quo_q;
          hi_q <= sign_a_q ? (~rem_q + 1'b1) : rem_q;
        end
        DONE: dz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dif.hi = hi_q;
  assign dif.lo = lo_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: vector table, random ops against an
// arithmetic reference, and hand-written abort/ignore sequences.
module tb_seq_div_unit;

  logic clk;
  logic reset;

  seq_div_unit_if #(.WIDTH(32)) dif ();

  seq_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl [10];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: signed 64-bit arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; the low 32 bits are the architected result.
  function automatic logic [63:0] ref_div(input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, q, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one op, count cycles to ready, then check the pulse drops.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input string nm,
                        output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdz);
    @(negedge clk);
    dif.start = 1'b1; dif.a = ta; dif.b = tb_v;
    @(posedge clk);
    #1 dif.start = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (dif.ready) break;
    end
    rhi = dif.hi; rlo = dif.lo; rdz = dif.div_zero;
    @(negedge clk);
    chk({nm, "_ready_drop"}, {63'd0, dif.ready}, 64'd0);
    chk({nm, "_idle_busy"}, {63'd0, dif.busy}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz;
    int nready;

    tbl[0] = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 34};
    tbl[1] = '{32'd5,        32'd0,          32'd14,         32'd2,          1'b1, 1};
    tbl[2] = '{32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34};
    tbl[3] = '{32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34};
    tbl[4] = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
    tbl[5] = '{32'd3,        32'd10,         32'd0,          32'd3,          1'b0, 34};
    tbl[6] = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0, 34};
    tbl[7] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34};
    tbl[8] = '{32'h7FFFFFFF, 32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 34};
    tbl[9] = '{32'h80000000, 32'h80000000,   32'd1,          32'd0,          1'b0, 34};

    dif.start = 1'b0; dif.a = '0; dif.b = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, dif.hi}, 64'd0);
    chk("rst_lo", {32'd0, dif.lo}, 64'd0);
    chk("rst_status", {61'd0, dif.ready, dif.div_zero, dif.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i), lat, rhi, rlo, rdz);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_lo", i), {32'd0, rlo}, {32'd0, tbl[i].lo});
      chk($sformatf("tbl%0d_hi", i), {32'd0, rhi}, {32'd0, tbl[i].hi});
      chk($sformatf("tbl%0d_dz", i), {63'd0, rdz}, {63'd0, tbl[i].dz});
    end
    m_lo = 32'd1; m_hi = 32'd0;

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] e;
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin rb = $urandom_range(1, 20); if ($urandom_range(0, 1) == 1) rb = -rb; end
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, $sformatf("rnd%0d", i), lat, rhi, rlo, rdz);
      if (rb == 32'd0) begin
        chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd1);
        chk($sformatf("rnd%0d_dz", i), {63'd0, rdz}, 64'd1);
      end else begin
        e = ref_div(ra, rb);
        m_hi = e[63:32]; m_lo = e[31:0];
        chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd34);
        chk($sformatf("rnd%0d_dz", i), {63'd0, rdz}, 64'd0);
      end
      chk($sformatf("rnd%0d_lo", i), {32'd0, rlo}, {32'd0, m_lo});
      chk($sformatf("rnd%0d_hi", i), {32'd0, rhi}, {32'd0, m_hi});
    end

    // Start while busy is ignored and operand changes after capture are harmless.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd100; dif.b = 32'd7;
    @(posedge clk);
    #1 dif.start = 1'b0;
    nready = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5)  begin dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3; end
      if (k == 6)  dif.start = 1'b0;
      if (k == 10) dif.a = 32'd123;
      if (dif.ready) begin
        nready++;
        chk("ign_lat", 64'(k), 64'd34);
        chk("ign_lo", {32'd0, dif.lo}, 64'd14);
        chk("ign_hi", {32'd0, dif.hi}, 64'd2);
      end
    end
    chk("ign_pulses", 64'(nready), 64'd1);

    // Reset mid-operation aborts with no ready.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd100; dif.b = 32'd7;
    @(posedge clk);
    #1 dif.start = 1'b0;
    for (int k = 1; k < 12; k++) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hi", {32'd0, dif.hi}, 64'd0);
    chk("abort_lo", {32'd0, dif.lo}, 64'd0);
    chk("abort_status", {61'd0, dif.ready, dif.div_zero, dif.busy}, 64'd0);
    nready = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.ready) nready++;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dif.ready) nready++;
    end
    chk("abort_no_ready", 64'(nready), 64'd0);
    run_op(32'd9, 32'd3, "post", lat, rhi, rlo, rdz);
    chk("post_lat", 64'(lat), 64'd34);
    chk("post_lo", {32'd0, rlo}, 64'd3);
    chk("post_hi", {32'd0, rhi}, 64'd0);
    chk("post_dz", {63'd0, rdz}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
